// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and helpers for the unified instruction/data memory.
// Contents: FSM state enum, sticky error bit indices, word width and the
// byte-lane merge used by both the array write path and the forwarding path.
package cpu_mem_pkg;

    localparam int WORD_W    = 32;
    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Replace each enabled byte lane of old_word with the matching lane of new_word.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// cpu_mem_if: bus between the core (master) and the memory (slave).
// Signals: instruction read request/address/word, data read request, byte
// write enables, data address/write data/read word, mem_ready, sticky err,
// write counter, and the memory FSM state for observation.
//
// Handshake: there is no per-request valid/ready pair. A request is the
// cycle in which instr_read, data_read or data_write is sampled high on a
// rising edge; it is accepted unconditionally whenever mem_ready is 1 and
// ignored while mem_ready is 0. Read words appear after that same edge and
// hold until the next accepted read on the same port.
interface cpu_mem_if #(parameter int CNT_W = 16);
    import cpu_mem_pkg::*;

    logic              instr_read;
    logic [31:0]       instr_addr;
    logic [WORD_W-1:0] instr_out;
    logic              data_read;
    logic [3:0]        data_write;
    logic [31:0]       data_addr;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              mem_ready;
    logic [1:0]        err;
    logic [CNT_W-1:0]  wr_cnt;
    state_t            state;

    modport master (
        output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        input  instr_out, data_out, mem_ready, err, wr_cnt, state
    );

    modport slave (
        input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        output instr_out, data_out, mem_ready, err, wr_cnt, state
    );

endinterface

// File: rtl/cpu_mem_bank.sv
// cpu_mem_bank: 2**ADDR_W x 32 storage with one byte-enabled write port and
// two synchronous read ports. A read and a write to the same word in one
// cycle return the old word (read-first).
// Ports: clk; we/waddr/wdata write port; re_a/raddr_a/rdata_a and
// re_b/raddr_b/rdata_b read ports (rdata holds while re is low).
module cpu_mem_bank
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WORD_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re_a) rdata_a <= mem[raddr_a];
        if (re_b) rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: unified instruction/data memory for the multi-cycle core.
// After reset release a clear sweep zeroes every word (one per cycle), then
// the memory serves the instruction read port and the data read/write port.
// Ports: clk, rst (synchronous, active-low), bus (cpu_mem_if.slave).
// Build option: define CPU_MEM_FWD_EN to make same-word write/read
// collisions write-first; otherwise reads return the pre-write word.
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic      clk,
    input  logic      rst,
    cpu_mem_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;

    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic              i_oor;
    logic              d_oor;
    logic              i_act;
    logic              d_rd;
    logic              d_act;
    logic              wr_ok;

    logic [3:0]        bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [WORD_W-1:0] bank_wdata;
    logic [WORD_W-1:0] bank_i;
    logic [WORD_W-1:0] bank_d;

    // Set when the last accepted read on a port was in range; outputs are
    // forced to zero otherwise (also covers reset and the clear sweep).
    logic              i_ok;
    logic              d_ok;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [WORD_W-1:0] i_word;
    logic [WORD_W-1:0] d_word;

    assign i_idx = bus.instr_addr[ADDR_W+1:2];
    assign d_idx = bus.data_addr[ADDR_W+1:2];
    assign i_oor = |(bus.instr_addr >> (ADDR_W + 2));
    assign d_oor = |(bus.data_addr >> (ADDR_W + 2));

    assign i_act = (state == READY) && bus.instr_read;
    assign d_rd  = (state == READY) && bus.data_read;
    assign d_act = (state == READY) && (bus.data_read || (bus.data_write != 4'h0));
    assign wr_ok = (state == READY) && (bus.data_write != 4'h0) && !d_oor;

    // State register; clr_idx wraps back to 0 as the sweep finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_idx == ADDR_W'(2**ADDR_W - 1)) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // During the sweep the array write port belongs to the clearer.
    always_comb begin
        bank_we    = 4'h0;
        bank_waddr = d_idx;
        bank_wdata = bus.data_in;
        if (state == CLEAR) begin
            bank_we    = 4'hF;
            bank_waddr = clr_idx;
            bank_wdata = '0;
        end else if (wr_ok) begin
            bank_we = bus.data_write;
        end
    end

    cpu_mem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .re_a    (i_act),
        .raddr_a (i_idx),
        .rdata_a (bank_i),
        .re_b    (d_rd),
        .raddr_b (d_idx),
        .rdata_b (bank_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_ok     <= 1'b0;
            d_ok     <= 1'b0;
            err_q    <= 2'b00;
            wr_cnt_q <= '0;
        end else begin
            if (i_act) i_ok <= !i_oor;
            if (d_rd)  d_ok <= !d_oor;
            if (wr_ok) wr_cnt_q <= wr_cnt_q + 1'b1;
            err_q[ERR_RANGE] <= err_q[ERR_RANGE] | (i_act & i_oor) | (d_act & d_oor);
            err_q[ERR_ALIGN] <= err_q[ERR_ALIGN]
                              | (i_act & (bus.instr_addr[1:0] != 2'b00))
                              | (d_act & (bus.data_addr[1:0] != 2'b00));
        end
    end

`ifdef CPU_MEM_FWD_EN
    // The bank returns the pre-write word; remember which lanes were written
    // to the same word in the read cycle and overlay them on the way out.
    logic [3:0]        i_fwd_be;
    logic [3:0]        d_fwd_be;
    logic [WORD_W-1:0] i_fwd_data;
    logic [WORD_W-1:0] d_fwd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_fwd_be   <= 4'h0;
            d_fwd_be   <= 4'h0;
            i_fwd_data <= '0;
            d_fwd_data <= '0;
        end else begin
            if (i_act) begin
                i_fwd_be   <= (wr_ok && (i_idx == d_idx)) ? bus.data_write : 4'h0;
                i_fwd_data <= bus.data_in;
            end
            if (d_rd) begin
                d_fwd_be   <= wr_ok ? bus.data_write : 4'h0;
                d_fwd_data <= bus.data_in;
            end
        end
    end

    assign i_word = byte_merge(bank_i, i_fwd_data, i_fwd_be);
    assign d_word = byte_merge(bank_d, d_fwd_data, d_fwd_be);
`else
    assign i_word = bank_i;
    assign d_word = bank_d;
`endif

    assign bus.instr_out = i_ok ? i_word : '0;
    assign bus.data_out  = d_ok ? d_word : '0;
    assign bus.mem_ready = (state == READY);
    assign bus.err       = err_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: self-checking bench for cpu_mem with ADDR_W=4 (16 words).
// Covers the clear sweep, byte-lane writes, range/alignment errors,
// same-cycle collisions (both CPU_MEM_FWD_EN builds), random traffic and
// reset during the sweep.
`timescale 1ns/1ps
module tb_cpu_mem;
    import cpu_mem_pkg::*;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_mem_if #(.CNT_W(CNT_W)) bus ();

    cpu_mem #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_i_q [$];
    logic [31:0] exp_d_q [$];
    logic [31:0] last_i;
    logic [31:0] last_d;
    logic [1:0]  exp_err;
    logic [15:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        if (be[0]) r[7:0]   = new_w[7:0];
        if (be[1]) r[15:8]  = new_w[15:8];
        if (be[2]) r[23:16] = new_w[23:16];
        if (be[3]) r[31:24] = new_w[31:24];
        return r;
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return a >= 32'd64;
    endfunction

    function automatic bit mis(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        exp_i_q.delete();
        exp_d_q.delete();
        last_i  = 32'h0;
        last_d  = 32'h0;
        exp_err = 2'b00;
        exp_cnt = 16'h0;
    endtask

    task automatic drive_idle();
        bus.instr_read = 1'b0;
        bus.instr_addr = 32'h0;
        bus.data_read  = 1'b0;
        bus.data_write = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_in    = 32'h0;
    endtask

    // Expected word a read of address a sees in the cycle of a write (dw,da,di).
    function automatic logic [31:0] read_view(input logic [31:0] a, input logic [3:0] dw,
                                              input logic [31:0] da, input logic [31:0] di);
        logic [31:0] w;
        if (oor(a)) return 32'h0;
        w = model[a[5:2]];
`ifdef CPU_MEM_FWD_EN
        if (dw != 4'h0 && !oor(da) && da[5:2] == a[5:2]) w = merge(w, di, dw);
`endif
        return w;
    endfunction

    // ---------------- driver: one in-service cycle ----------------
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] di);
        bus.instr_read = ir;
        bus.instr_addr = ia;
        bus.data_read  = dr;
        bus.data_write = dw;
        bus.data_addr  = da;
        bus.data_in    = di;
        if (ir) exp_i_q.push_back(read_view(ia, dw, da, di));
        if (dr) exp_d_q.push_back(read_view(da, dw, da, di));
        if (dw != 4'h0 && !oor(da)) begin
            model[da[5:2]] = merge(model[da[5:2]], di, dw);
            exp_cnt++;
        end
        if ((ir && oor(ia)) || ((dr || dw != 4'h0) && oor(da))) exp_err[0] = 1'b1;
        if ((ir && mis(ia)) || ((dr || dw != 4'h0) && mis(da))) exp_err[1] = 1'b1;
        @(posedge clk);
        #1;
        if (ir && exp_i_q.size() > 0) last_i = exp_i_q.pop_front();
        if (dr && exp_d_q.size() > 0) last_d = exp_d_q.pop_front();
        check("instr_out", bus.instr_out, last_i);
        check("data_out", bus.data_out, last_d);
        check("err", 32'(bus.err), 32'(exp_err));
        check("wr_cnt", 32'(bus.wr_cnt), 32'(exp_cnt));
        check("mem_ready", 32'(bus.mem_ready), 32'd1);
        drive_idle();
    endtask

    // Release already applied; hammer the ports during the sweep and count
    // edges until mem_ready rises.
    task automatic wait_sweep(input string tag);
        int n;
        bit seen;
        seen = 1'b0;
        bus.instr_read = 1'b1;
        bus.instr_addr = 32'h40;
        bus.data_read  = 1'b1;
        bus.data_write = 4'hF;
        bus.data_addr  = 32'h6;
        bus.data_in    = 32'hFFFF_FFFF;
        for (n = 1; n <= 3 * DEPTH; n++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        drive_idle();
        if (!seen) $display("FAIL %s_timeout: got no mem_ready expected mem_ready", tag);
        check({tag, "_ready_edges"}, 32'(n), 32'(DEPTH));
        check({tag, "_state"}, 32'(bus.state), 32'(READY));
        check({tag, "_err"}, 32'(bus.err), 32'h0);
        check({tag, "_wr_cnt"}, 32'(bus.wr_cnt), 32'h0);
        check({tag, "_instr_out"}, bus.instr_out, 32'h0);
        check({tag, "_data_out"}, bus.data_out, 32'h0);
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'h0);
        check({tag, "_err"}, 32'(bus.err), 32'h0);
        check({tag, "_wr_cnt"}, 32'(bus.wr_cnt), 32'h0);
        check({tag, "_instr_out"}, bus.instr_out, 32'h0);
        check({tag, "_data_out"}, bus.data_out, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] coll_exp;
        drive_idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        wait_sweep("sweep");

        // All words cleared; both ports in parallel.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'((DEPTH - 1 - i) * 4), 1'b1, 4'h0, 32'(i * 4), 32'h0);

        // Byte-lane update.
        cycle(1'b0, 32'h0, 1'b0, 4'hF, 32'h8, 32'hDEAD_BEEF);
        cycle(1'b0, 32'h0, 1'b0, 4'b0010, 32'h8, 32'h0000_5500);
        cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        check("byte_lane_word", bus.data_out, 32'hDEAD_55EF);
        check("byte_lane_cnt", 32'(bus.wr_cnt), 32'd2);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); // hold

        // Out-of-range instruction read and write.
        cycle(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0);
        check("oor_err", 32'(bus.err), 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 4'hF, 32'h40, 32'h1234_5678);
        cycle(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("oor_err_sticky", 32'(bus.err), 32'h1);

        // Misaligned data read uses the word index.
        cycle(1'b0, 32'h0, 1'b0, 4'hF, 32'h4, 32'hCAFE_F00D);
        cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h6, 32'h0);
        check("misaligned_word", bus.data_out, 32'hCAFE_F00D);
        check("misaligned_err", 32'(bus.err), 32'h3);

        // Same-cycle collision on word 0.
        cycle(1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 32'hAAAA_AAAA);
`ifdef CPU_MEM_FWD_EN
        coll_exp = 32'h1122_3344;
`else
        coll_exp = 32'hAAAA_AAAA;
`endif
        cycle(1'b1, 32'h0, 1'b1, 4'hF, 32'h0, 32'h1122_3344);
        check("collision_instr", bus.instr_out, coll_exp);
        check("collision_data", bus.data_out, coll_exp);
        cycle(1'b1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);

        // Random traffic, collisions included.
        for (int k = 0; k < 60; k++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'($urandom_range(0, 15) * 4), $urandom());
        end

        // Reset from service, then again part way through the sweep.
        cycle(1'b0, 32'h0, 1'b0, 4'hF, 32'h8, 32'h5A5A_5A5A);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_ready");
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midsweep_ready", 32'(bus.mem_ready), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_midsweep");
        rst = 1'b1;
        wait_sweep("resweep");
        cycle(1'b1, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        check("resweep_word8", bus.data_out, 32'h0);

        check("queues_drained", 32'(exp_i_q.size() + exp_d_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem.md
# cpu_mem

Unified instruction/data memory that answers the multi-cycle RISC-V core's memory interface. Serves a read-only instruction port and a read/write data port with per-byte write enables from a single word-organized array. Read data is registered one cycle after address. A post-reset clear sequencer zeroes the array before service begins.

## Interface
- ADDR_W, 10: word-address bits; DEPTH = 2**ADDR_W words, byte space 0 .. 4*DEPTH-1
- CNT_W, 16: width of write-transaction counter
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- instr_read  input  1  instruction read request
- instr_addr  input  32  instruction byte address
- instr_out  output  32  registered instruction word
- data_read  input  1  data read request
- data_write  input  4  byte write enables, bit n writes data_in[8n+7:8n]
- data_addr  input  32  data byte address
- data_in  input  32  write data
- data_out  output  32  registered data word
- mem_ready  output  1  clear sweep done, memory in service
- err  output  2  sticky: bit0 out-of-range access, bit1 misaligned access
- wr_cnt  output  CNT_W  count of accepted write cycles, wraps

## Operation
- Word index = addr[ADDR_W+1:2]; out-of-range when addr[31:ADDR_W+2] != 0.
- FSM states: CLEAR, READY.
  - rst=0: state <= CLEAR, clr_idx <= 0; instr_out, data_out, err, wr_cnt <= 0; mem_ready <= 0.
  - CLEAR: mem[clr_idx] <= 0 each cycle, clr_idx increments; when clr_idx == DEPTH-1 the final word is written and state <= READY, mem_ready <= 1 on that edge.
  - READY: terminal until rst.
- During CLEAR: requests ignored, no write, outputs hold 0, err and wr_cnt unchanged.
- READY, instr_read=1: instr_out <= mem[idx(instr_addr)], or 0 if out-of-range. instr_read=0: hold.
- READY, data_read=1: data_out <= mem[idx(data_addr)], or 0 if out-of-range. Hold otherwise.
- READY, data_write != 0, in range: each enabled byte lane updated; wr_cnt += 1 (wraps at 2**CNT_W). Out-of-range write: no array change, no count.
- err[0] set on any active port request out-of-range. err[1] set on any active request with addr[1:0] != 0. Misaligned access still uses word index (low bits ignored). Bits clear only on rst.
- Same-cycle data write and read (either port) to the same word: read-first. Returned value is the pre-write word (see Configuration).

## Timing
- Read latency 1 cycle: address valid at edge N gives data at outputs after edge N; stable until next accepted read.
- Write commits at the edge where data_write is sampled nonzero; visible to a read issued the next cycle.
- Clear sweep: DEPTH cycles after the first cycle with rst=1; mem_ready rises after edge DEPTH.
- rst=0 mid-sweep: sweep restarts from index 0. rst=0 in READY: array contents not re-preserved, full re-clear.
- No backpressure: the responder never stalls a request once mem_ready=1.

## Configuration
- CPU_MEM_FWD_EN defined: same-word read/write collision is write-first. Both read ports return the old word merged with enabled bytes of data_in.
- Undefined: read-first as above. Array write path identical in both builds.

## Structure
- Package cpu_mem_pkg: state enum (CLEAR, READY), ERR_RANGE=0 / ERR_ALIGN=1 bit indices, WORD_W=32, byte-merge function (old word, new word, 4-bit enable).
- Sub-module cpu_mem_bank: DEPTH x 32 array, 4 byte-lane write enables, one write port, two synchronous read ports. The FSM, error flags, counter and forwarding live in cpu_mem.

## Test plan
- ADDR_W=4: rst low 2 cycles then high -> mem_ready rises after exactly 16 cycles; all 16 words read 0; requests during sweep leave err=0, wr_cnt=0.
- Write 0xDEADBEEF at 0x8 with data_write=4'hF, then data_write=4'b0010 data_in=0x00005500 -> read 0x8 returns 0xDEAD55EF one cycle after request; wr_cnt=2.
- instr_addr=0x40 (ADDR_W=4) -> instr_out=0, err=2'b01 and stays set; write to 0x40 -> no wr_cnt change.
- data_read at 0x6 -> returns word 1, err[1]=1.
- Same cycle: write 0x11223344 to 0x0 (previously 0xAAAAAAAA) and read 0x0 on both ports -> 0xAAAAAAAA without macro, 0x11223344 with CPU_MEM_FWD_EN.
- rst low at sweep cycle 5 -> mem_ready stays 0; full 16-cycle sweep follows release; data written before reset reads 0.
